// File: rtl/yolo_pkg.sv
// yolo_pkg
//   Shared definitions for the image front end: default pixel-word geometry,
//   default image size and pixel-memory address width, and the state
//   enumeration used by image_stream_source.
package yolo_pkg;

    localparam int YOLO_DATA_WIDTH = 32;   // one IEEE-754 single per channel
    localparam int YOLO_CHANNELS   = 3;    // channels packed per pixel word
    localparam int YOLO_IMG_SIZE   = 416;  // square image edge length
    localparam int YOLO_ADDR_WIDTH = 18;   // covers 416*416 pixel indices

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_e;

endpackage

// File: rtl/image_stream_source_if.sv
// image_stream_source_if
//   Pixel-memory read port plus the outgoing pixel stream.
//   master : image_stream_source (drives reads and the pixel stream)
//   slave  : memory / consumer side
//   Signals: mem_rd_en, mem_addr, mem_rdata (valid one cycle after mem_rd_en),
//            data_out, valid_out, ready_in (transfer = valid_out && ready_in).
interface image_stream_source_if
    import yolo_pkg::*;
#(
    parameter int DATA_WIDTH = YOLO_DATA_WIDTH,
    parameter int CHANNELS   = YOLO_CHANNELS,
    parameter int ADDR_WIDTH = YOLO_ADDR_WIDTH
);
    logic                             mem_rd_en;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [DATA_WIDTH*CHANNELS-1:0]   mem_rdata;
    logic [DATA_WIDTH*CHANNELS-1:0]   data_out;
    logic                             valid_out;
    logic                             ready_in;

    modport master (
        output mem_rd_en, mem_addr, data_out, valid_out,
        input  mem_rdata, ready_in
    );

    modport slave (
        input  mem_rd_en, mem_addr, data_out, valid_out,
        output mem_rdata, ready_in
    );
endinterface

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer
//   Two-entry FIFO with valid/ready on both sides. The head entry drives the
//   output directly, so out_data_o is registered and holds while stalled.
//   Ports: clk_i, rst_i (sync, active high),
//          in_valid_i / in_ready_o / in_data_i   : write side
//          out_valid_o / out_ready_i / out_data_o : read side
//          count_o : current occupancy (0..2)
module stream_skid_buffer #(
    parameter int WIDTH = 96
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = count_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data_i;
                else                 tail_d = in_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // occupancy unchanged; new word lands behind whatever remains
                if (count_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/image_stream_source.sv
// image_stream_source
//   On a start pulse, reads one square image from pixel memory in row-major
//   order and streams it as one pixel word per valid/ready transfer.
//   Optional build macro IMAGE_STREAM_ZERO_PAD_EN adds a one-pixel zero border
//   ((IMG_SIZE+2)^2 words); border slots issue no memory read.
//   Ports: clk_i, rst_i (sync, active high), start_i, busy_o, done_o,
//          bus (image_stream_source_if.master: memory read port + pixel stream).
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for start; no reads, no valid output
//   ST_STREAM | issuing one read/pad slot per cycle when credit allows
//   ST_DRAIN  | all slots issued, waiting for the last transfer
//   ST_DONE   | one cycle, done_o high, then back to idle
module image_stream_source
    import yolo_pkg::*;
#(
    parameter int DATA_WIDTH = YOLO_DATA_WIDTH,
    parameter int CHANNELS   = YOLO_CHANNELS,
    parameter int IMG_SIZE   = YOLO_IMG_SIZE,
    parameter int ADDR_WIDTH = YOLO_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    image_stream_source_if.master bus
);
    localparam int WORD_W = DATA_WIDTH * CHANNELS;
`ifdef IMAGE_STREAM_ZERO_PAD_EN
    localparam int EDGE = IMG_SIZE + 2;
`else
    localparam int EDGE = IMG_SIZE;
`endif
    localparam int CNT_W = (EDGE > 1) ? $clog2(EDGE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(EDGE - 1);

    stream_state_e         state_q, state_d;
    logic [CNT_W-1:0]      row_q, row_d, col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  infl_q;
    logic                  issue, slot_rd, last_slot, credit_ok;
    logic                  fifo_pop, fifo_in_ready;
    logic [1:0]            fifo_count;
    logic [WORD_W-1:0]     fifo_in_data;
    logic                  unused_fifo_in_ready;

`ifdef IMAGE_STREAM_ZERO_PAD_EN
    logic slot_pad, pad_q;
    assign slot_pad = (row_q == '0) || (row_q == LAST) || (col_q == '0) || (col_q == LAST);
    assign slot_rd  = !slot_pad;
    assign fifo_in_data = pad_q ? '0 : bus.mem_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) pad_q <= 1'b0;
        else       pad_q <= issue && slot_pad;
    end
`else
    assign slot_rd      = 1'b1;
    assign fifo_in_data = bus.mem_rdata;
`endif

    // Credit counts this cycle's pop so a steady ready_in sustains one slot
    // per cycle; it also guarantees the FIFO has room when the word returns.
    assign fifo_pop  = bus.valid_out && bus.ready_in;
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, infl_q}) < (3'd2 + {2'b00, fifo_pop});
    assign last_slot = (row_q == LAST) && (col_q == LAST);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_STREAM: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (slot_rd) addr_d = addr_q + 1'b1;
                    if (last_slot) begin
                        state_d = ST_DRAIN;
                        row_d   = '0;
                        col_d   = '0;
                        addr_d  = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && (fifo_count == 2'd1) && !infl_q) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            infl_q  <= issue;
        end
    end

    assign bus.mem_rd_en = issue && slot_rd;
    assign bus.mem_addr  = addr_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);

    stream_skid_buffer #(.WIDTH(WORD_W)) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (infl_q),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   (fifo_in_data),
        .out_valid_o (bus.valid_out),
        .out_ready_i (bus.ready_in),
        .out_data_o  (bus.data_out),
        .count_o     (fifo_count)
    );

    // Returned words always find room thanks to the credit check above.
    assign unused_fifo_in_ready = fifo_in_ready;
endmodule

// File: tb/tb_image_stream_source.sv
module tb_image_stream_source;
    localparam int IMG = 4;
`ifdef IMAGE_STREAM_ZERO_PAD_EN
    localparam int EDGE = IMG + 2;
`else
    localparam int EDGE = IMG;
`endif
    localparam int NPIX = EDGE * EDGE;
    localparam int W    = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic clr_max = 1'b0;
    logic busy, done;

    image_stream_source_if #(.DATA_WIDTH(32), .CHANNELS(3), .ADDR_WIDTH(18)) bus_if ();

    image_stream_source #(
        .DATA_WIDTH(32), .CHANNELS(3), .IMG_SIZE(IMG), .ADDR_WIDTH(18)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // Pixel memory: word i = {3{i}}; junk when not read so latency errors show.
    always @(posedge clk)
        bus_if.mem_rdata <= bus_if.mem_rd_en ? {3{32'(bus_if.mem_addr)}} : {3{32'hDEAD_BEEF}};

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // Transfer / read / done monitor, sampled mid-cycle.
    logic [W-1:0] xd [0:1023];
    int           xe [0:1023];
    int xfer_cnt = 0, rd_cnt = 0, done_cnt = 0, done_edge = 0, outst = 0, max_out = 0;

    always @(negedge clk) begin
        int o;
        o = outst;
        if (!rst) begin
            if (bus_if.valid_out && bus_if.ready_in) begin
                if (xfer_cnt < 1024) begin
                    xd[xfer_cnt] <= bus_if.data_out;
                    xe[xfer_cnt] <= ecnt;
                end
                xfer_cnt <= xfer_cnt + 1;
                o = o - 1;
            end
            if (bus_if.mem_rd_en) begin
                rd_cnt <= rd_cnt + 1;
                o = o + 1;
            end
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= ecnt;
        end
        if (rst) outst <= 0;
        else     outst <= o;
        if (clr_max)                  max_out <= 0;
        else if (!rst && o > max_out) max_out <= o;
    end

    int n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_word(input int idx);
        int r, c, p;
        r = idx / EDGE;
        c = idx % EDGE;
`ifdef IMAGE_STREAM_ZERO_PAD_EN
        if (r == 0 || r == EDGE-1 || c == 0 || c == EDGE-1) return '0;
        p = (r - 1) * IMG + (c - 1);
`else
        p = r * IMG + c;
`endif
        return {3{p[31:0]}};
    endfunction

    task automatic start_image(output int n);
        start = 1'b1;
        cycle();
        n = ecnt;
        start = 1'b0;
    endtask

    task automatic wait_done(input int db, input int limit, input string tag);
        int g = 0;
        while (done_cnt == db && g < limit) begin
            cycle();
            g++;
        end
        chk({tag, "_done_seen"}, done_cnt != db, 1'b1);
    endtask

    task automatic check_seq(input int base, input string tag);
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("%s_px%0d", tag, i), xd[base + i], exp_word(i));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy, 1'b0);
        chk({tag, "_done"},      done, 1'b0);
        chk({tag, "_rd_en"},     bus_if.mem_rd_en, 1'b0);
        chk({tag, "_addr"},      bus_if.mem_addr, 18'd0);
        chk({tag, "_valid"},     bus_if.valid_out, 1'b0);
        chk({tag, "_data"},      bus_if.data_out, 96'd0);
    endtask

    initial begin
        int n, base, db, rb, g;
        bus_if.ready_in = 1'b1;

        // Reset state
        repeat (3) cycle();
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (2) cycle();
        chk("idle_rd_en", bus_if.mem_rd_en, 1'b0);
        chk("idle_valid", bus_if.valid_out, 1'b0);

        // Full image, ready held high: latency, throughput, order, one done
        base = xfer_cnt; db = done_cnt; rb = rd_cnt;
        start_image(n);
        chk("lat_busy", busy, 1'b1);
        chk("lat_rd_en", bus_if.mem_rd_en, 1'b1);
        chk("lat_addr0", bus_if.mem_addr, 18'd0);
        cycle();
        chk("lat_no_valid_yet", bus_if.valid_out, 1'b0);
        wait_done(db, 200, "t1");
        chk("t1_count", xfer_cnt - base, NPIX);
        check_seq(base, "t1");
        for (int i = 0; i < NPIX; i++)
            chk($sformatf("t1_edge%0d", i), xe[base + i], n + 2 + i);
        chk("t1_done_edge", done_edge, n + 2 + NPIX);
        chk("t1_reads", rd_cnt - rb, IMG * IMG);
        repeat (2) cycle();
        chk("t1_done_once", done_cnt - db, 1);
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_rd_en", bus_if.mem_rd_en, 1'b0);
        chk("t1_idle_valid", bus_if.valid_out, 1'b0);

        // Back-pressure for five cycles: output frozen, nothing lost
        clr_max = 1'b1; cycle(); clr_max = 1'b0;
        base = xfer_cnt; db = done_cnt;
        start_image(n);
        repeat (5) cycle();
        bus_if.ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_stall_valid%0d", k), bus_if.valid_out, 1'b1);
            chk($sformatf("t2_stall_data%0d", k), bus_if.data_out, exp_word(3));
            cycle();
        end
        bus_if.ready_in = 1'b1;
        wait_done(db, 200, "t2");
        chk("t2_count", xfer_cnt - base, NPIX);
        check_seq(base, "t2");
        chk("t2_max_outstanding", max_out, 2);
        chk("t2_done_once", done_cnt - db, 1);

        // Reset after seven transfers, then replay from pixel 0
        base = xfer_cnt;
        start_image(n);
        g = 0;
        while (xfer_cnt - base < 7 && g < 100) begin
            cycle();
            g++;
        end
        chk("t3_reached7", (xfer_cnt - base) >= 7, 1'b1);
        rst = 1'b1;
        cycle();
        check_reset_outputs("t3_rst");
        rst = 1'b0;
        cycle();
        base = xfer_cnt; db = done_cnt;
        start_image(n);
        wait_done(db, 200, "t3");
        chk("t3_count", xfer_cnt - base, NPIX);
        check_seq(base, "t3");

        // start pulses while busy are ignored
        base = xfer_cnt; db = done_cnt;
        start_image(n);
        repeat (3) cycle();
        start = 1'b1; cycle(); start = 1'b0;
        repeat (6) cycle();
        start = 1'b1; cycle(); start = 1'b0;
        wait_done(db, 200, "t4");
        repeat (5) cycle();
        chk("t4_count", xfer_cnt - base, NPIX);
        chk("t4_done_once", done_cnt - db, 1);
        chk("t4_idle_busy", busy, 1'b0);
        check_seq(base, "t4");

        // Random ready_in: same sequence as the reference
        base = xfer_cnt; db = done_cnt;
        start_image(n);
        g = 0;
        while (done_cnt == db && g < 800) begin
            bus_if.ready_in = 1'($urandom_range(0, 1));
            cycle();
            g++;
        end
        bus_if.ready_in = 1'b1;
        chk("t5_done_seen", done_cnt != db, 1'b1);
        chk("t5_count", xfer_cnt - base, NPIX);
        check_seq(base, "t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/image_stream_source.md
IMAGE_STREAM_SOURCE -- requirements
Module: image_stream_source

Interface
REQ-001 Parameter DATA_WIDTH, 32, bits per channel sample (IEEE-754 single).
REQ-002 Parameter CHANNELS, 3, channels packed per pixel word; channel c occupies bits [32c+31:32c].
REQ-003 Parameter IMG_SIZE, 416, square image edge length in pixels.
REQ-004 Parameter ADDR_WIDTH, 18, pixel-memory address width.
REQ-005 Clk  in  1  single clock; all logic on rising edge.
REQ-006 Rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to stream one image; honoured only in IDLE.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  one-cycle pulse after the final pixel transfer.
REQ-010 mem_rd_en  out  1  pixel-memory read strobe.
REQ-011 mem_addr  out  ADDR_WIDTH  pixel index, row-major, 0..IMG_SIZE^2-1.
REQ-012 mem_rdata  in  DATA_WIDTH*CHANNELS  read data, valid exactly one cycle after mem_rd_en.
REQ-013 data_out  out  DATA_WIDTH*CHANNELS  pixel word to the layer-0 feature-map blocks' data_in.
REQ-014 valid_out  out  1  data_out holds a pixel.
REQ-015 ready_in  in  1  consumer accepts; transfer = valid_out && ready_in.

Function
REQ-016 States: IDLE, STREAM (issuing reads), DRAIN (all reads issued, buffer non-empty), DONE (one cycle, done=1) -> IDLE.
REQ-017 IDLE -> STREAM on start; start while busy is ignored.
REQ-018 Pixels are emitted strictly row-major, one word per transfer, CHANNELS samples unmodified.
REQ-019 Output buffering: 2-entry skid FIFO; a read (or pad slot) issues only when FIFO occupancy plus in-flight slots < 2.
REQ-020 With ready_in held high, mem_rd_en is asserted every cycle: sustained one pixel per cycle.
REQ-021 Latency: start sampled at edge N -> mem_rd_en/addr 0 in cycle N+1 -> first valid_out in cycle N+3.
REQ-022 valid_out, once high, stays high with data_out stable until transfer.
REQ-023 mem_addr maintained by incrementing counter (no multiplier); row/col counters wrap col at IMG_SIZE-1.
REQ-024 STREAM -> DRAIN when the last slot issues; DRAIN -> DONE on last transfer; empty FIFO in DRAIN impossible.
REQ-025 Between images (IDLE) mem_rd_en=0 and valid_out=0.

Reset
REQ-026 Rst, including mid-image: state=IDLE, counters=0, FIFO flushed, in-flight read discarded.
REQ-027 Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, valid_out=0, data_out=0.

Configuration
REQ-028 Macro IMAGE_STREAM_ZERO_PAD_EN defined: emit (IMG_SIZE+2)^2 pixels, 1-pixel zero border, interior read from memory.
REQ-029 Pad slots issue no memory read, travel the same 1-cycle tag pipeline as reads, yield data_out=0, preserve order and latency.
REQ-030 Macro undefined: exactly IMG_SIZE^2 pixels, no pad logic synthesized.

Structure
REQ-031 Shared package yolo_pkg: DATA_WIDTH, CHANNELS, IMG_SIZE defaults, state enumeration constants.
REQ-032 One sub-module: stream_skid_buffer (2-entry, valid/ready both sides, width parameterized).

Verification
REQ-033 IMG_SIZE=4, memory word i = {3{i}}, ready_in=1, start -> 16 transfers 0..15 in consecutive cycles from cycle N+3, done once after the 16th.
REQ-034 ready_in low cycles 5-9 -> data_out frozen, no pixel lost or duplicated, at most 2 reads outstanding.
REQ-035 Rst asserted after 7 transfers -> next cycle all outputs 0; new start replays from pixel 0.
REQ-036 start pulsed while busy -> ignored, exactly 16 transfers, one done.
REQ-037 ZERO_PAD_EN, IMG_SIZE=4 -> 36 transfers; indices 0-6 zero, index 7 = pixel 0, index 35 zero; 16 memory reads total.
REQ-038 ready_in random 50% -> output sequence identical to REQ-033 reference.
